shake_dout_fifo: RTL
====================

Name: shake_dout_fifo

Overview:
Downstream stage of the SHAKE/cSHAKE core. Consumes the core's dout valid/ready word stream and captures exactly a programmed number of digest words per hash into an on-chip FIFO. The APB slave then drains the FIFO at CPU pace, so no digest word is lost or re-read. Sits between keccak_top dout and the APB read-data mux.

Parameters:
WIDTH, 32, word width; equals the core dout width and the APB data width
DEPTH, 16, FIFO depth in words; power of two, at least 2
LEN_W, 8, width of the per-hash word-count field

Ports:
io_mainClk  in  1  system clock
io_systemReset  in  1  reset, asynchronous, active-low
clear  in  1  synchronous flush, driven alongside the core reset strobe
start  in  1  one-cycle pulse; arms capture of out_len words
out_len  in  LEN_W  words to capture per hash; sampled on start
s_valid  in  1  core dout_valid
s_ready  out  1  to core dout_ready
s_data  in  WIDTH  core dout
m_rd  in  1  one-cycle pop strobe from the APB data-register read
m_valid  out  1  FIFO not empty
m_data  out  WIDTH  head word, first-word-fall-through
count  out  clog2(DEPTH)+1  FIFO occupancy
busy  out  1  FSM is in CAPTURE
done  out  1  FSM is in DONE
err  out  1  sticky error flag (see Optional Feature)

Behaviour:
- Reset (io_systemReset=0, async): state IDLE; pointers, count and remaining set to 0. Outputs: s_ready=0, m_valid=0, m_data=0, busy=0, done=0, err=0.
- FSM states: IDLE, CAPTURE, DONE.
  - IDLE: s_ready=0. start with out_len!=0 latches remaining=out_len and moves to CAPTURE. start with out_len==0 is ignored.
  - CAPTURE: s_ready = !full, combinational from registered full. A push occurs on s_valid && s_ready, writes s_data at wr_ptr and decrements remaining. A push while remaining==1 moves to DONE on the next edge.
  - DONE: s_ready=0 and done=1. start with out_len!=0 re-arms into CAPTURE with the FIFO contents kept.
  - start in CAPTURE is ignored.
- Pop: occurs on m_rd && m_valid; rd_ptr advances. m_rd while empty is ignored. m_data is the memory word at rd_ptr and is valid in the cycle m_valid=1; it is don't-care (held) when empty.
- Push and pop in the same cycle: count is unchanged and both pointers advance. Full blocks the push through s_ready=0, so a word is never overwritten.
- Pointers are clog2(DEPTH) bits wide and wrap modulo DEPTH. full = (count==DEPTH), empty = (count==0).
- Latency: a word pushed at edge N is visible on m_data with m_valid=1 after edge N when the FIFO was empty.
- clear (sync): highest priority over start, push and pop in the same cycle. Empties the FIFO, sets state IDLE, remaining=0, err=0.
- Reset asserted mid-capture aborts immediately. The partially captured words are discarded.

Optional Feature:
Macro SHAKE_DOUT_FIFO_ERR_EN.
- With the macro: err is set on either of two events and stays set until clear or reset.
  - m_rd while empty (underflow).
  - start asserted while in CAPTURE (premature restart).
- Without the macro: err is tied to 0 and no sticky logic is built. The port is always present.

Decomposition:
- Package shake_pkg holds:
  - the state enum: IDLE, CAPTURE, DONE;
  - default WIDTH=32 and LEN_W=8 constants;
  - the APB offset constants for the status/data registers that consume done, count and m_data.
- One sub-module: shake_sync_fifo. It holds the memory, pointers, count and full/empty, with push, pop and clear inputs. shake_dout_fifo adds the FSM, the word counter and err.

Test Plan:
1. Reset then out_len=4, start; stream 0xA0..0xA3 with s_valid held high -> s_ready high 4 cycles; done=1 the cycle after the 4th push; count=4. Four m_rd pops return A0,A1,A2,A3; m_valid=0 after the last pop.
2. DEPTH=16, out_len=20, no pops -> s_ready drops after 16 pushes, count=16, busy=1. Pop 1 word -> exactly one more push (0x10th word). Drain all -> 20 words in order, done=1.
3. Push and m_rd in the same cycle at count=3 -> count stays 3; the head advances by one word.
4. clear asserted the same cycle as a push and a start, mid-capture at count=5 -> next cycle count=0, IDLE, s_ready=0, done=0.
5. io_systemReset pulsed low between clock edges during CAPTURE -> all outputs 0 immediately, without waiting for a clock edge.
6. With SHAKE_DOUT_FIFO_ERR_EN: m_rd while empty -> err=1 and count stays 0; err stays high until clear. Without the macro: the same stimulus leaves err=0.

Source files
------------

// File: rtl/shake_pkg.sv
// Shared types and constants for the SHAKE digest-output path.
// The state encoding is shared by the FIFO front end and the APB status decode.
package shake_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam int SHAKE_WIDTH = 32;
  localparam int SHAKE_LEN_W = 8;

  // APB register offsets that expose done/count (status) and the FIFO head (data).
  localparam logic [7:0] APB_STATUS_OFS = 8'h00;
  localparam logic [7:0] APB_DATA_OFS   = 8'h04;

endpackage

// File: rtl/shake_dout_fifo_if.sv
// Digest word stream: core-side valid/ready push and APB-side pop strobe.
// slave = the FIFO stage, master = whoever drives the core and APB sides.
interface shake_dout_fifo_if #(
  parameter int WIDTH = 32
);
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             m_rd;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;

  modport slave  (input  s_valid, s_data, m_rd,
                  output s_ready, m_valid, m_data);
  modport master (output s_valid, s_data, m_rd,
                  input  s_ready, m_valid, m_data);
endinterface

// File: rtl/shake_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with a synchronous flush.
// Push while full and pop while empty are ignored; clear wins over both.
module shake_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     io_mainClk,
  input  logic                     io_systemReset,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  // Forced to zero when empty so the reset state of the head is defined.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // NOTE: the storage array has no reset; empty gating of rd_data covers it.
  always_ff @(posedge io_mainClk) begin
    if (push_ok && !clear) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge io_mainClk or negedge io_systemReset) begin
    if (!io_systemReset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/shake_dout_fifo.sv
// Captures a programmed number of core digest words per hash into a FIFO drained by APB.
// Define SHAKE_DOUT_FIFO_ERR_EN to build the sticky underflow / premature-restart err flag.
module shake_dout_fifo
  import shake_pkg::*;
#(
  parameter int WIDTH = SHAKE_WIDTH,
  parameter int DEPTH = 16,
  parameter int LEN_W = SHAKE_LEN_W
) (
  input  logic                   io_mainClk,
  input  logic                   io_systemReset,
  input  logic                   clear,
  input  logic                   start,
  input  logic [LEN_W-1:0]       out_len,
  shake_dout_fifo_if.slave       bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);
  state_t           state, state_nxt;
  logic [LEN_W-1:0] remaining;
  logic             full, empty, push, pop, arm;

  assign push = bus.s_valid && bus.s_ready;
  assign pop  = bus.m_rd && bus.m_valid;
  assign arm  = start && (out_len != '0) && (state != CAPTURE);
  assign bus.m_valid = !empty;

  shake_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .io_mainClk     (io_mainClk),
    .io_systemReset (io_systemReset),
    .clear          (clear),
    .push           (push),
    .wr_data        (bus.s_data),
    .pop            (pop),
    .rd_data        (bus.m_data),
    .count          (count),
    .full           (full),
    .empty          (empty)
  );

  always_ff @(posedge io_mainClk or negedge io_systemReset) begin
    if (!io_systemReset) state <= IDLE;
    else                 state <= state_nxt;
  end

  // NOTE: every comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (arm) state_nxt = CAPTURE;
        CAPTURE:    if (push && remaining == LEN_W'(1)) state_nxt = DONE;
        default:    state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.s_ready = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      CAPTURE: begin
        bus.s_ready = !full;
        busy        = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge io_mainClk or negedge io_systemReset) begin
    if (!io_systemReset)   remaining <= '0;
    else if (clear)        remaining <= '0;
    else if (arm)          remaining <= out_len;
    else if (push)         remaining <= remaining - LEN_W'(1);
  end

`ifdef SHAKE_DOUT_FIFO_ERR_EN
  logic err_q;
  always_ff @(posedge io_mainClk or negedge io_systemReset) begin
    if (!io_systemReset) err_q <= 1'b0;
    else if (clear)      err_q <= 1'b0;
    else if ((bus.m_rd && empty) || (start && state == CAPTURE)) err_q <= 1'b1;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
